// File: rtl/gpu_mem_pkg.sv
// Shared frame-buffer memory definitions for the arbiter and the rendering engines.
package gpu_mem_pkg;

   localparam int unsigned AddrWDefault = 24;
   localparam int unsigned DataWDefault = 1536;
   localparam int unsigned OwnerW       = 3;
   localparam int unsigned HoldCntW     = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_picker #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned IDX_W   = 3
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   logic             valid_hi;
   logic             valid_lo;
   logic [IDX_W-1:0] win_hi;
   logic [IDX_W-1:0] win_lo;

   // Descending scan so the lowest matching index is the last one written.
   always_comb begin
      valid_hi = 1'b0;
      valid_lo = 1'b0;
      win_hi   = '0;
      win_lo   = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req[j]) begin
            valid_lo = 1'b1;
            win_lo   = IDX_W'(j);
            if (IDX_W'(j) >= ptr) begin
               valid_hi = 1'b1;
               win_hi   = IDX_W'(j);
            end
         end
      end
      valid  = valid_lo;
      winner = valid_hi ? win_hi : win_lo;
   end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin owner arbiter for the shared frame-buffer SRAM port, with a zero-latency
// combinational pass-through for the granted engine plus hold-timeout and protocol flags.
module sram_arbiter
   import gpu_mem_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 3,
   parameter int unsigned ADDR_W   = AddrWDefault,
   parameter int unsigned DATA_W   = DataWDefault,
   parameter int unsigned MAX_HOLD = 4096
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic [NUM_REQ-1:0]          req,
   output logic [NUM_REQ-1:0]          gnt,
   input  logic [NUM_REQ-1:0]          req_read_enable,
   input  logic [NUM_REQ-1:0]          req_write_enable,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
   input  logic [NUM_REQ*DATA_W-1:0]   req_write_data,
   output logic [DATA_W-1:0]           req_read_data,
   output logic                        mem_read_enable,
   output logic                        mem_write_enable,
   output logic [ADDR_W-1:0]           mem_address,
   output logic [DATA_W-1:0]           mem_write_data,
   input  logic [DATA_W-1:0]           mem_read_data,
   output logic                        busy,
   output logic [OwnerW-1:0]           owner,
   output logic                        hold_timeout,
   output logic                        proto_err,
   input  logic                        stat_clr
);

   localparam logic [HoldCntW-1:0] MaxHoldCnt = HoldCntW'(MAX_HOLD);
   localparam logic [HoldCntW-1:0] HoldCntMax = {HoldCntW{1'b1}};

   arb_state_t            state_q, state_d;
   logic [NUM_REQ-1:0]    gnt_q, gnt_d;
   logic [OwnerW-1:0]     owner_q, owner_d;
   logic [OwnerW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [HoldCntW-1:0]   hold_cnt_q, hold_cnt_d;
   logic                  hold_timeout_q, hold_timeout_d;
   logic                  proto_err_q, proto_err_d;

   logic [OwnerW-1:0]     owner_inc;
   logic [OwnerW-1:0]     pick_ptr;
   logic [OwnerW-1:0]     winner;
   logic                  pick_valid;
   logic                  owner_req;
   logic [NUM_REQ-1:0]    winner_oh;

   always_comb begin
      owner_inc = owner_q + OwnerW'(1);
      if (owner_q == OwnerW'(NUM_REQ - 1)) begin
         owner_inc = '0;
      end
   end

   // In RELEASE the pick already uses the advanced pointer being written this cycle.
   assign pick_ptr  = (state_q == RELEASE) ? owner_inc : rr_ptr_q;
   assign owner_req = |(req & gnt_q);

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (OwnerW)
   ) u_rr_picker (
      .req    (req),
      .ptr    (pick_ptr),
      .winner (winner),
      .valid  (pick_valid)
   );

   always_comb begin
      winner_oh = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         winner_oh[r] = (winner == OwnerW'(r));
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      hold_cnt_d = hold_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d    = BUSY;
               gnt_d      = winner_oh;
               owner_d    = winner;
               hold_cnt_d = '0;
            end
         end
         BUSY: begin
            hold_cnt_d = (hold_cnt_q == HoldCntMax) ? hold_cnt_q : hold_cnt_q + HoldCntW'(1);
            if (!owner_req) begin
               state_d = RELEASE;
               gnt_d   = '0;
            end
         end
         RELEASE: begin
            rr_ptr_d = owner_inc;
            if (pick_valid) begin
               state_d    = BUSY;
               gnt_d      = winner_oh;
               owner_d    = winner;
               hold_cnt_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // Sticky flags: clear first so a same-cycle set condition wins.
   always_comb begin
      hold_timeout_d = stat_clr ? 1'b0 : hold_timeout_q;
      proto_err_d    = stat_clr ? 1'b0 : proto_err_q;
      if ((state_q == BUSY) && (hold_cnt_d == MaxHoldCnt)) begin
         hold_timeout_d = 1'b1;
      end
      if (|((req_read_enable | req_write_enable) & ~gnt_q)) begin
         proto_err_d = 1'b1;
      end
   end

   always_comb begin
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
      mem_address      = '0;
      mem_write_data   = '0;
      req_read_data    = '0;
      if (state_q == BUSY) begin
         req_read_data = mem_read_data;
         for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt_q[r]) begin
               mem_read_enable  = req_read_enable[r];
               mem_write_enable = req_write_enable[r];
               mem_address      = req_address[r*ADDR_W +: ADDR_W];
               mem_write_data   = req_write_data[r*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q        <= IDLE;
         gnt_q          <= '0;
         owner_q        <= '0;
         rr_ptr_q       <= '0;
         hold_cnt_q     <= '0;
         hold_timeout_q <= 1'b0;
         proto_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         gnt_q          <= gnt_d;
         owner_q        <= owner_d;
         rr_ptr_q       <= rr_ptr_d;
         hold_cnt_q     <= hold_cnt_d;
         hold_timeout_q <= hold_timeout_d;
         proto_err_q    <= proto_err_d;
      end
   end

   assign gnt          = gnt_q;
   assign busy         = (state_q == BUSY);
   assign owner        = owner_q;
   assign hold_timeout = hold_timeout_q;
   assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: grant order, pass-through, flags and mid-write reset.
module tb_sram_arbiter;

   localparam int NR = 3;
   localparam int AW = 24;
   localparam int DW = 1536;

   logic              clk = 1'b0;
   logic              n_rst;
   logic [NR-1:0]     req, gnt, re, we;
   logic [NR*AW-1:0]  addr;
   logic [NR*DW-1:0]  wdata;
   logic [DW-1:0]     rrd, mwd, mrd;
   logic [AW-1:0]     maddr;
   logic              mre, mwe, busy, hto, perr, stat_clr;
   logic [2:0]        owner;

   int n_checks = 0;
   int n_errors = 0;
   int order [4] = '{0, 1, 2, 0};
   logic [NR-1:0] oh;
   logic [DW-1:0] wpat1;

   sram_arbiter #(
      .NUM_REQ  (NR),
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .MAX_HOLD (8)
   ) dut (
      .clk              (clk),
      .n_rst            (n_rst),
      .req              (req),
      .gnt              (gnt),
      .req_read_enable  (re),
      .req_write_enable (we),
      .req_address      (addr),
      .req_write_data   (wdata),
      .req_read_data    (rrd),
      .mem_read_enable  (mre),
      .mem_write_enable (mwe),
      .mem_address      (maddr),
      .mem_write_data   (mwd),
      .mem_read_data    (mrd),
      .busy             (busy),
      .owner            (owner),
      .hold_timeout     (hto),
      .proto_err        (perr),
      .stat_clr         (stat_clr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      n_rst    = 1'b0;
      req      = '0;
      re       = '0;
      we       = '0;
      stat_clr = 1'b0;
      tick();
      tick();
      n_rst = 1'b1;
   endtask

   initial begin
      addr               = '0;
      addr[0*AW +: AW]   = 24'h111111;
      addr[1*AW +: AW]   = 24'h000100;
      addr[2*AW +: AW]   = 24'h222222;
      wpat1              = {64{24'h5A5A5A}};
      wdata              = '0;
      wdata[1*DW +: DW]  = wpat1;
      wdata[2*DW +: DW]  = {64{24'h333333}};
      mrd                = {64{24'hABC123}};
      do_reset();
      check("rst_gnt", 64'(gnt), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_owner", 64'(owner), 64'h0);
      check("rst_flags", 64'({hto, perr}), 64'h0);
      check("rst_rdata", rrd[63:0], 64'h0);

      // Single requester read pass-through
      req = 3'b010;
      tick();
      check("t1_gnt", 64'(gnt), 64'h2);
      check("t1_owner", 64'(owner), 64'h1);
      check("t1_busy", 64'(busy), 64'h1);
      re = 3'b010;
      #1;
      check("t1_mre", 64'(mre), 64'h1);
      check("t1_maddr", 64'(maddr), 64'h000100);
      check("t1_rdata", 64'(rrd == mrd), 64'h1);
      check("t1_rdata_lo", rrd[63:0], mrd[63:0]);
      re  = '0;
      req = '0;
      tick();
      check("t1_rel_gnt", 64'(gnt), 64'h0);
      check("t1_rel_busy", 64'(busy), 64'h0);
      check("t1_rel_maddr", 64'(maddr), 64'h0);
      check("t1_rel_rdata", rrd[63:0], 64'h0);
      check("t1_perr", 64'(perr), 64'h0);
      tick();

      // All three requesting from reset: order 0,1,2,0 with one RELEASE between
      do_reset();
      req = 3'b111;
      for (int k = 0; k < 4; k++) begin
         oh = '0;
         oh[order[k]] = 1'b1;
         tick();
         check($sformatf("t2_gnt%0d", k), 64'(gnt), 64'(oh));
         check($sformatf("t2_owner%0d", k), 64'(owner), 64'(order[k]));
         repeat (4) tick();
         check($sformatf("t2_hold%0d", k), 64'(gnt), 64'(oh));
         req[order[k]] = 1'b0;
         tick();
         check($sformatf("t2_rel%0d", k), 64'({gnt, busy}), 64'h0);
         req[order[k]] = 1'b1;
      end
      check("t2_hto", 64'(hto), 64'h0);
      req = '0;
      tick();
      tick();

      // Drop and re-raise lands behind the pending requester
      do_reset();
      req = 3'b010;
      tick();
      check("t3_gnt1", 64'(gnt), 64'h2);
      req = 3'b110;
      tick();
      check("t3_keep1", 64'(gnt), 64'h2);
      req = 3'b100;
      tick();
      check("t3_rel", 64'(gnt), 64'h0);
      req = 3'b110;
      tick();
      check("t3_reraise", 64'(gnt), 64'h4);
      req = 3'b010;
      tick();
      tick();
      check("t3_gnt1b", 64'(gnt), 64'h2);

      // Non-owner strobe is blocked and flagged
      we = 3'b100;
      #1;
      check("t4_mwe_blk", 64'(mwe), 64'h0);
      tick();
      we = '0;
      check("t4_perr", 64'(perr), 64'h1);
      tick();
      check("t4_sticky", 64'(perr), 64'h1);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      check("t4_clr", 64'(perr), 64'h0);
      we = 3'b010;
      #1;
      check("t4_own_mwe", 64'(mwe), 64'h1);
      check("t4_own_wd", mwd[63:0], wpat1[63:0]);
      check("t4_own_addr", 64'(maddr), 64'h000100);
      tick();
      we = '0;
      check("t4_own_noerr", 64'(perr), 64'h0);
      stat_clr = 1'b1;
      re       = 3'b001;
      tick();
      stat_clr = 1'b0;
      re       = '0;
      check("t4_set_wins", 64'(perr), 64'h1);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      check("t4_clr2", 64'(perr), 64'h0);
      req = '0;
      tick();
      tick();

      // Hold timeout after the 8th BUSY cycle, grant kept
      do_reset();
      req = 3'b001;
      tick();
      check("t5_gnt", 64'(gnt), 64'h1);
      repeat (7) tick();
      check("t5_pre", 64'(hto), 64'h0);
      tick();
      check("t5_hto", 64'(hto), 64'h1);
      check("t5_gnt_kept", 64'(gnt), 64'h1);
      repeat (11) tick();
      check("t5_gnt_20", 64'(gnt), 64'h1);
      check("t5_hto_sticky", 64'(hto), 64'h1);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      check("t5_clr", 64'(hto), 64'h0);
      req = '0;
      tick();
      tick();

      // Reset during a write by requester 2; pointer returns to 0
      do_reset();
      req = 3'b010;
      tick();
      req = '0;
      tick();
      tick();
      req = 3'b100;
      tick();
      check("t6_gnt2", 64'(gnt), 64'h4);
      we = 3'b100;
      #1;
      check("t6_mwe", 64'(mwe), 64'h1);
      n_rst = 1'b0;
      tick();
      check("t6_gnt", 64'(gnt), 64'h0);
      check("t6_mwe0", 64'(mwe), 64'h0);
      check("t6_busy", 64'(busy), 64'h0);
      check("t6_perr", 64'(perr), 64'h0);
      n_rst = 1'b1;
      we    = '0;
      req   = 3'b111;
      tick();
      check("t6_ptr0", 64'(gnt), 64'h1);
      check("t6_owner0", 64'(owner), 64'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
